// File: rtl/regs_pkg.sv
// Shared constants and scan FSM encoding for the register file readout path.
package regs_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/regfile_scan_reader_if.sv
// Output stream of the scan reader: {addr,data,dirty} under a valid/ready handshake.
interface regfile_scan_reader_if #(
  parameter int ADDR_W = regs_pkg::ADDR_W_DEF,
  parameter int DATA_W = regs_pkg::DATA_W_DEF
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              dirty;

  modport master (output valid, addr, data, dirty, input ready);
  modport slave  (input valid, addr, data, dirty, output ready);

endinterface

// File: rtl/stream_out_reg.sv
// Holding register for one emitted word; tracks whether the file overwrote it
// between capture and acceptance.
module stream_out_reg
  import regs_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_i,
  input  logic [ADDR_W-1:0]     cap_addr_i,
  input  logic [DATA_W-1:0]     cap_data_i,
  input  logic                  abort_i,
  input  logic                  mon_we_i,
  input  logic [ADDR_W-1:0]     mon_waddr_i,
  regfile_scan_reader_if.master out_if
);

  logic              valid_q, valid_d;
  logic              dirty_q, dirty_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              stale_hit;

  // R0 is hardwired, so a write there can never make the word stale.
  assign stale_hit = mon_we_i && (mon_waddr_i == addr_q) && (addr_q != ADDR_W'(REG_ZERO));

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (abort_i) begin
      valid_d = 1'b0;
      dirty_d = 1'b0;
    end else if (cap_i) begin
      valid_d = 1'b1;
      dirty_d = 1'b0;
      addr_d  = cap_addr_i;
      data_d  = cap_data_i;
    end else if (valid_q) begin
      if (out_if.ready) valid_d = 1'b0;
      if (stale_hit) dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign out_if.valid = valid_q;
  assign out_if.dirty = dirty_q;
  assign out_if.addr  = addr_q;
  assign out_if.data  = data_q;

endmodule

// File: rtl/regfile_scan_reader.sv
// Walks the register file read port FIRST_ADDR..LAST_ADDR and streams each word
// out for debug dumps while the datapath keeps running.
//   state | meaning
//   IDLE  | waiting for start, read port parked on FIRST_ADDR
//   READ  | read port on addr_q, word captured at the edge
//   HOLD  | word presented, waiting for the consumer
//   DONE  | one-cycle completion pulse
module regfile_scan_reader
  import regs_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  skip_zero_i,
  output logic [ADDR_W-1:0]     rd_addr_o,
  input  logic [DATA_W-1:0]     rd_data_i,
  input  logic                  mon_we_i,
  input  logic [ADDR_W-1:0]     mon_waddr_i,
  regfile_scan_reader_if.master out_if,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ADDR_W-1:0] FIRST_A    = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] SKIP_A     = (FIRST_ADDR == 0) ? ADDR_W'(1) : FIRST_A;
  localparam bit                EMPTY_SKIP = (FIRST_ADDR == 0) && (LAST_ADDR == 0);

  scan_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              done_q;
  logic              handshake;

  assign handshake = out_if.valid && out_if.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= FIRST_A;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort_i) begin
      state_q <= ST_IDLE;
      addr_q  <= FIRST_A;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            // Skipping R0 on a scan that only covers R0 leaves nothing to emit.
            if (skip_zero_i && EMPTY_SKIP) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= skip_zero_i ? SKIP_A : FIRST_A;
              state_q <= ST_READ;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_READ: state_q <= ST_HOLD;
        ST_HOLD: begin
          if (handshake) begin
            if (addr_q == LAST_A) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          addr_q  <= FIRST_A;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_addr_o = (state_q == ST_READ || state_q == ST_HOLD) ? addr_q : FIRST_A;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  stream_out_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_stream_out_reg (
    .clk        (clk),
    .rst        (rst),
    .cap_i      (state_q == ST_READ),
    .cap_addr_i (addr_q),
    .cap_data_i (rd_data_i),
    .abort_i    (abort_i),
    .mon_we_i   (mon_we_i),
    .mon_waddr_i(mon_waddr_i),
    .out_if     (out_if)
  );

endmodule
